// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and the transmitter.
//   uart_state_t        : receiver state encoding
//   clks_per_bit()      : system clocks per serial bit (integer divide)
//   half_bit()          : clocks from start edge to mid start bit
//   DATA_BITS           : payload width of an 8N1 frame
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int half_bit(input int clk_hz, input int baud);
        return clks_per_bit(clk_hz, baud) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk : system clock
//   rst : synchronous active-high reset, loads RST_VAL into both flops
//   d   : asynchronous input
//   q   : synchronized output, two clocks behind d
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic ff1_reg;
    logic ff2_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff1_reg <= RST_VAL;
            ff2_reg <= RST_VAL;
        end else begin
            ff1_reg <= d;
            ff2_reg <= ff1_reg;
        end
    end

    assign q = ff2_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   rx_in     : asynchronous serial input
//   data_out  : last correctly framed byte, held until the next good frame
//   valid     : one-clock pulse when data_out has just been updated
//   frame_err : one-clock pulse when the stop bit was sampled low
//   busy      : high whenever the receiver is not idle
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int HALF_BIT     = half_bit(CLK_HZ, BAUD);
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);

    logic rx_s;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx_in),
        .q  (rx_s)
    );

    uart_state_t    state_reg,     state_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic [2:0]     bit_idx_reg,   bit_idx_next;
    logic [7:0]     shift_reg,     shift_next;
    logic [7:0]     data_reg,      data_next;
    logic           valid_reg,     valid_next;
    logic           frame_err_reg, frame_err_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg + 1'b1;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        data_next      = data_reg;
        valid_next     = 1'b0;
        frame_err_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = ST_START;
                end
            end

            // Re-check the line at mid start bit; a high level means the
            // falling edge was only a glitch.
            ST_START: begin
                if (cnt_reg == CNT_HALF_END) begin
                    if (!rx_s) begin
                        state_next   = ST_DATA;
                        bit_idx_next = '0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end

            // Sampling one full bit after the mid-start point lands in the
            // middle of each data bit.
            ST_DATA: begin
                if (cnt_reg == CNT_BIT_END) begin
                    cnt_next                = '0;
                    shift_next[bit_idx_reg] = rx_s;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end

            ST_STOP: begin
                if (cnt_reg == CNT_BIT_END) begin
                    if (rx_s) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = ST_WAIT_IDLE;
                    end
                end
            end

            // A line stuck low must not be mistaken for new start bits.
            ST_WAIT_IDLE: begin
                cnt_next = '0;
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (state_next != state_reg) begin
            cnt_next = '0;
        end
    end

    assign data_out  = data_reg;
    assign valid     = valid_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at default parameters (434 clk/bit).
// The sender knows when each start edge is driven, so the expected pulse
// kind, data and arrival cycle are computed from the frame contents and the
// fixed receive latency; one compare process checks every cycle.
module tb_uart_rx;

    localparam int CPB  = 50_000_000 / 115200;   // 434
    localparam int HALF = CPB / 2;               // 217
    // Drive cycle of the start edge to cycle the pulse is visible:
    // 1 (first flop) + 2 (synchronizer to state) + HALF + 9 bits.
    localparam int LAT  = 3 + HALF + 9 * CPB;

    typedef struct {
        int         t;
        logic       err;
        logic [7:0] d;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx dut (
        .clk      (clk),
        .rst      (rst),
        .rx_in    (rx_in),
        .data_out (data_out),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         total = 0;
    int         bad = 0;
    evt_t       exp_q[$];
    evt_t       cur_evt;
    logic [7:0] model_data = 8'h00;
    int         busy_lo = -1;
    int         busy_hi = -2;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         last_valid_cyc = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison against the expected-event queue.
    always @(negedge clk) begin
        if (!rst) begin
            check("exclusive", int'(valid && frame_err), 0);
            if (valid) begin
                n_valid++;
                last_valid_cyc = cyc;
            end
            if (frame_err) n_ferr++;
            if (valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    cur_evt = exp_q.pop_front();
                    check("pulse_kind", int'(frame_err), int'(cur_evt.err));
                    check("pulse_time", int'(cyc >= cur_evt.t - 1 && cyc <= cur_evt.t + 1), 1);
                    if (!cur_evt.err) model_data = cur_evt.d;
                    $display("pulse cyc=%0d kind=%s data_out=%02h", cyc,
                             frame_err ? "ferr" : "valid", data_out);
                end
            end
            if (exp_q.size() > 0 && cyc > exp_q[0].t + 1) begin
                check("missing_pulse", 0, 1);
                void'(exp_q.pop_front());
            end
            check("data_out", int'(data_out), int'(model_data));
            if (cyc >= busy_lo && cyc <= busy_hi) check("busy", int'(busy), 1);
        end
    end

    task automatic do_reset();
        rx_in = 1'b1;
        rst   = 1'b1;
        exp_q.delete();
        busy_lo = -1;
        busy_hi = -2;
        wait_cycles(3);
        model_data = 8'h00;
        check("rst_data_out", int'(data_out), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
    endtask

    // stop_low: bit periods the stop bit is held low (0 = good frame).
    // abort_bit: frame bit index (0 = start) at which reset is applied, -1 none.
    task automatic send_byte(input logic [7:0] d, input int p, input int stop_low,
                             input int abort_bit);
        int n;
        logic [9:0] bits;
        n    = cyc;
        bits = {1'b1, d, 1'b0};
        busy_lo = n + 4;
        if (abort_bit < 0) begin
            exp_q.push_back('{t: n + LAT, err: (stop_low != 0), d: d});
            busy_hi = n + LAT - 2;
        end else begin
            busy_hi = n + abort_bit * p - 2;
        end
        $display("send data=%02h period=%0d stop_low=%0d abort=%0d cyc=%0d",
                 d, p, stop_low, abort_bit, n);
        for (int k = 0; k < 10; k++) begin
            if (k == abort_bit) begin
                do_reset();
                return;
            end
            if (k == 9 && stop_low > 0) begin
                rx_in = 1'b0;
                wait_cycles(stop_low * p);
                check("wait_idle_hold", int'(busy), 1);
            end else begin
                rx_in = bits[k];
                wait_cycles(p);
            end
        end
        rx_in = 1'b1;
    endtask

    initial begin
        int nv;
        int nf;
        int n;
        logic [7:0] d;
        int p;
        int sel;

        wait_cycles(2);
        do_reset();
        wait_cycles(20);

        // 0x41 nominal frame; pin the absolute latency with a literal.
        n = cyc;
        send_byte(8'h41, CPB, 0, -1);
        wait_cycles(20);
        check("lat_0x41", int'(last_valid_cyc - n >= 4125 && last_valid_cyc - n <= 4127), 1);
        check("data_0x41", int'(data_out), 8'h41);
        check("ferr_none_0x41", n_ferr, 0);

        // 100-clk glitch.
        nv = n_valid;
        nf = n_ferr;
        n  = cyc;
        busy_lo = n + 4;
        busy_hi = n + 215;
        rx_in = 1'b0;
        wait_cycles(100);
        rx_in = 1'b1;
        wait_cycles(125);
        check("glitch_idle", int'(busy), 0);
        check("glitch_no_valid", n_valid, nv);
        check("glitch_no_ferr", n_ferr, nf);
        wait_cycles(20);

        // 0x55 with stop low for two bit times.
        nf = n_ferr;
        send_byte(8'h55, CPB, 2, -1);
        wait_cycles(5);
        check("ferr_count", n_ferr - nf, 1);
        check("ferr_keeps_data", int'(data_out), 8'h41);
        check("ferr_released", int'(busy), 0);
        wait_cycles(20);

        // Back-to-back 0x00, 0xFF.
        nv = n_valid;
        send_byte(8'h00, CPB, 0, -1);
        send_byte(8'hFF, CPB, 0, -1);
        wait_cycles(20);
        check("b2b_count", n_valid - nv, 2);
        check("b2b_data", int'(data_out), 8'hFF);

        // Reset during bit 4 of 0xA5, then 0x3C.
        nv = n_valid;
        send_byte(8'hA5, CPB, 0, 5);
        wait_cycles(30);
        check("abort_no_pulse", n_valid, nv);
        send_byte(8'h3C, CPB, 0, -1);
        wait_cycles(20);
        check("after_abort_data", int'(data_out), 8'h3C);

        // +/-2% baud offset on 0xC3.
        nf = n_ferr;
        send_byte(8'hC3, 425, 0, -1);
        wait_cycles(20);
        check("fast_c3", int'(data_out), 8'hC3);
        send_byte(8'h00, CPB, 0, -1);
        send_byte(8'hC3, 443, 0, -1);
        wait_cycles(20);
        check("slow_c3", int'(data_out), 8'hC3);
        check("offset_no_ferr", n_ferr, nf);

        // Randomized frames, some with a bad stop bit.
        for (int i = 0; i < 6; i++) begin
            d   = 8'($urandom);
            p   = $urandom_range(426, 442);
            sel = $urandom_range(0, 4);
            send_byte(d, p, (sel == 0) ? 1 : 0, -1);
            wait_cycles($urandom_range(0, 40) + ((sel == 0) ? 20 : 0));
        end

        wait_cycles(50);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Port clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port rx_in  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 Port data_out  output  8  last correctly framed byte; held until the next good frame.
REQ-007 Port valid  output  1  one-clk pulse, data_out newly updated.
REQ-008 Port frame_err  output  1  one-clk pulse, stop bit sampled low.
REQ-009 Port busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 rx_in SHALL pass through a 2-flop synchronizer; rx_s denotes its output, which is 2 clk behind rx_in.
REQ-011 CLKS_PER_BIT SHALL be CLK_HZ/BAUD (integer divide; 434 at defaults), and HALF_BIT SHALL be CLKS_PER_BIT/2 (217).
REQ-012 The bit counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL clear on every state change.
REQ-013 States: IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-014 IDLE: rx_s==0 -> START, counter=0.
REQ-015 START: at counter==HALF_BIT-1, rx_s==0 -> DATA with bit_idx=0; rx_s==1 -> IDLE (glitch rejected, no pulse).
REQ-016 DATA: at counter==CLKS_PER_BIT-1, shift[bit_idx]<=rx_s; bit_idx 7 -> STOP, else bit_idx+1.
REQ-017 STOP: at counter==CLKS_PER_BIT-1, rx_s==1 -> data_out<=shift, valid=1 for one clk, -> IDLE.
REQ-018 STOP with rx_s==0 -> frame_err=1 for one clk, data_out unchanged, -> WAIT_IDLE.
REQ-019 WAIT_IDLE: remain until rx_s==1, then -> IDLE; a line held low SHALL NOT produce further frames or pulses.
REQ-020 valid and frame_err SHALL never be high in the same cycle.
REQ-021 Latency SHALL be fixed: valid asserts 2 + HALF_BIT + 9*CLKS_PER_BIT clk after the rx_in falling edge of the start bit (±1 clk).
REQ-022 A start edge arriving in the clk directly after valid SHALL be accepted; back-to-back frames SHALL not be dropped.
REQ-023 There is no backpressure: a new good frame overwrites data_out, and the consumer samples on valid.

Reset
REQ-024 While rst=1: state=IDLE, counter=0, bit_idx=0, shift=0, data_out=0, valid=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame without a pulse; reception resumes on the first falling edge after rst deasserts.

Structure
REQ-026 The state encodings and the CLKS_PER_BIT/HALF_BIT derivation SHALL reside in a shared package/include, uart_pkg, for reuse by the transmitter.
REQ-027 The synchronizer SHALL be a separate sub-module, sync_2ff (reset value parameterized, 1 here); all remaining logic is inline.

Verification
REQ-028 0x41 sent at 434 clk/bit -> one valid pulse, data_out=0x41, busy high throughout the frame, and frame_err never asserted.
REQ-029 A 100-clk low glitch on an idle line -> returns to IDLE after HALF_BIT, with no valid and no frame_err.
REQ-030 0x55 sent with the stop bit driven low for 2 bit times -> frame_err pulses once, data_out keeps its prior value, and the block holds in WAIT_IDLE until the line rises.
REQ-031 0x00 then 0xFF sent back-to-back with no idle gap -> two valid pulses carrying 0x00 then 0xFF.
REQ-032 rst asserted at bit 4 of 0xA5, then 0x3C sent -> no pulse for the aborted frame, then valid with data_out=0x3C.
REQ-033 A ±2% baud-rate offset on 0xC3 -> data_out=0xC3 with no frame_err.
